// File: rtl/nukv_fifo_packer.sv
// rtl/nukv_fifo_packer.sv - packs RATIO narrow stream words into one FWFT FIFO entry (optional NUKV_PACKER_TIMEOUT_EN flush)
module nukv_fifo_packer #(
  parameter int IN_WIDTH     = 64,
  parameter int RATIO        = 4,
  parameter int FLUSH_CYCLES = 64,
  localparam int CNT_BITS    = $clog2(RATIO) + 1,
  localparam int OUT_SIZE    = RATIO * IN_WIDTH + CNT_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [OUT_SIZE-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic                m_axis_talmostfull
);

  localparam int LANE_BITS = $clog2(RATIO);
  localparam int ACC_W     = RATIO * IN_WIDTH;

  typedef enum logic {EMPTY, FILL} state_e;

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   lane_q, lane_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      acc_w;
  logic [OUT_SIZE-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  rdy_en_q;
  logic                  accept;
  logic                  out_free;
  int                    lane_idx;

  // Input is held off during reset and for the cycle reset releases in
  assign s_axis_tready = rdy_en_q && !m_axis_talmostfull && !(out_valid_q && !m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_free      = !out_valid_q || m_axis_tready;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign lane_idx      = int'(lane_q[LANE_BITS-1:0]);

`ifdef NUKV_PACKER_TIMEOUT_EN
  localparam int IDLE_BITS = $clog2(FLUSH_CYCLES + 1);
  logic [IDLE_BITS-1:0] idle_q, idle_d;
  logic                 flush;

  // A partial entry is flushed only when no word arrives that cycle
  assign flush = (state_q == FILL) && !accept && (idle_q >= IDLE_BITS'(FLUSH_CYCLES)) && out_free;

  // Idle counter: counts non-accept cycles in FILL, saturating at the limit
  always_comb begin
    idle_d = idle_q;
    if (state_q == EMPTY || accept || flush) begin
      idle_d = '0;
    end else if (idle_q < IDLE_BITS'(FLUSH_CYCLES)) begin
      idle_d = idle_q + IDLE_BITS'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`else
  logic flush;
  logic unused_flush_cycles;
  assign flush               = 1'b0;
  assign unused_flush_cycles = (FLUSH_CYCLES > 0);
`endif

  // Next-state: fill lanes, emit on the last lane, on tlast, or on flush
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    acc_w       = acc_q;
    acc_w[lane_idx*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
    if (accept) begin
      if (lane_q == CNT_BITS'(RATIO - 1) || s_axis_tlast) begin
        out_data_d  = {s_axis_tlast, lane_q + CNT_BITS'(1), acc_w};
        out_valid_d = 1'b1;
        acc_d       = '0;
        lane_d      = '0;
        state_d     = EMPTY;
      end else begin
        acc_d   = acc_w;
        lane_d  = lane_q + CNT_BITS'(1);
        state_d = FILL;
      end
    end else if (flush) begin
      out_data_d  = {1'b0, lane_q, acc_q};
      out_valid_d = 1'b1;
      acc_d       = '0;
      lane_d      = '0;
      state_d     = EMPTY;
    end
  end

  // State, accumulator and one-deep output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      lane_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nukv_fifo_packer.sv
// tb/tb_nukv_fifo_packer.sv - self-checking bench for nukv_fifo_packer with a queue-based reference model
module tb_nukv_fifo_packer;

  localparam int IN_WIDTH = 64;
  localparam int RATIO    = 4;
  localparam int FLUSH    = 64;
  localparam int CNT_BITS = $clog2(RATIO) + 1;
  localparam int OUT_SIZE = RATIO * IN_WIDTH + CNT_BITS + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [IN_WIDTH-1:0] s_axis_tdata = '0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tlast = 1'b0;
  logic                s_axis_tready;
  logic [OUT_SIZE-1:0] m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b1;
  logic                m_axis_talmostfull = 1'b0;

  nukv_fifo_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_talmostfull(m_axis_talmostfull)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_writes = 0;

  logic [IN_WIDTH-1:0] words[$];
  logic                m_valid = 1'b0;
  logic [OUT_SIZE-1:0] m_data = '0;
  logic                m_en = 1'b0;
  int                  m_idle = 0;
  logic                m_acc = 1'b0;

  task automatic chk(input logic [OUT_SIZE-1:0] obs, input logic [OUT_SIZE-1:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_SIZE-1:0] build(input logic last);
    logic [OUT_SIZE-1:0] e;
    e = '0;
    foreach (words[i]) e[i*IN_WIDTH +: IN_WIDTH] = words[i];
    e[RATIO*IN_WIDTH +: CNT_BITS] = CNT_BITS'(words.size());
    e[OUT_SIZE-1] = last;
    return e;
  endfunction

  task automatic cycle();
    logic exp_ready;
    logic nv;
    logic free;
    @(negedge clk);
    exp_ready = m_en && !m_axis_talmostfull && !(m_valid && !m_axis_tready);
    chk(OUT_SIZE'(s_axis_tready), OUT_SIZE'(exp_ready), "s_axis_tready");
    chk(OUT_SIZE'(m_axis_tvalid), OUT_SIZE'(m_valid), "m_axis_tvalid");
    if (m_valid) chk(m_axis_tdata, m_data, "m_axis_tdata");
    if (m_axis_tvalid && m_axis_tready) dut_writes++;
    m_acc = s_axis_tvalid && exp_ready;
    @(posedge clk);
    free = !m_valid || m_axis_tready;
    nv = m_valid && !m_axis_tready;
    if (m_acc) begin
      words.push_back(s_axis_tdata);
      m_idle = 0;
      if (words.size() == RATIO || s_axis_tlast) begin
        m_data = build(s_axis_tlast);
        nv = 1'b1;
        words.delete();
      end
    end else if (words.size() > 0) begin
`ifdef NUKV_PACKER_TIMEOUT_EN
      if (m_idle >= FLUSH && free) begin
        m_data = build(1'b0);
        nv = 1'b1;
        words.delete();
        m_idle = 0;
      end else begin
        m_idle++;
      end
`else
      m_idle = free ? m_idle : m_idle;
`endif
    end
    m_valid = nv;
    m_en = rst;
    #1;
  endtask

  task automatic send(input logic [IN_WIDTH-1:0] d, input logic last);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_acc && n < 40);
    chk(OUT_SIZE'(m_acc), OUT_SIZE'(1), "send_accept_timeout");
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk(OUT_SIZE'(m_axis_tvalid), '0, "reset_tvalid");
    chk(OUT_SIZE'(s_axis_tready), '0, "reset_tready");
    chk(m_axis_tdata, '0, "reset_tdata");
    words.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_idle  = 0;
    m_en    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int w0;
    #3;
    do_reset();
    idle(2);

    // four words with tlast on the fourth
    send(64'h11, 1'b0); send(64'h22, 1'b0); send(64'h33, 1'b0); send(64'h44, 1'b1);
    chk(m_axis_tdata, {1'b1, 3'd4, 64'h44, 64'h33, 64'h22, 64'h11}, "entry_4_last");
    idle(2);

    // six words, tlast on the sixth
    w0 = dut_writes;
    for (int i = 1; i <= 6; i++) send(IN_WIDTH'(i), i == 6);
    cycle();
    chk(m_axis_tdata, {1'b1, 3'd2, 64'h0, 64'h0, 64'h6, 64'h5}, "entry_b_partial");
    idle(2);
    chk(OUT_SIZE'(dut_writes - w0), OUT_SIZE'(2), "six_word_writes");

    // almost-full stall with valid input
    m_axis_talmostfull = 1'b1;
    s_axis_tdata = 64'hAA; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    w0 = dut_writes;
    idle(10);
    chk(OUT_SIZE'(dut_writes - w0), '0, "almostfull_no_writes");
    m_axis_talmostfull = 1'b0;
    s_axis_tvalid = 1'b0;
    send(64'hAA, 1'b1);
    idle(2);

    // full stall with an entry pending
    m_axis_tready = 1'b0;
    send(64'h5A5A, 1'b1);
    idle(6);
    w0 = dut_writes;
    m_axis_tready = 1'b1;
    idle(3);
    chk(OUT_SIZE'(dut_writes - w0), OUT_SIZE'(1), "release_one_write");

    // timeout flush of a three-word partial entry
    w0 = dut_writes;
    send(64'h1, 1'b0); send(64'h2, 1'b0); send(64'h3, 1'b0);
    idle(60);
    chk(OUT_SIZE'(dut_writes - w0), '0, "no_early_flush");
    idle(20);
`ifdef NUKV_PACKER_TIMEOUT_EN
    chk(OUT_SIZE'(dut_writes - w0), OUT_SIZE'(1), "timeout_flush_count");
`else
    chk(OUT_SIZE'(dut_writes - w0), '0, "no_timeout_flush");
`endif

    // reset in the middle of a fill
    send(64'h77, 1'b0); send(64'h78, 1'b0);
    #2;
    w0 = dut_writes;
    do_reset();
    idle(5);
    chk(OUT_SIZE'(dut_writes - w0), '0, "reset_discards_partial");
    send(64'h99, 1'b1);
    cycle();
    chk(m_axis_tdata, {1'b1, 3'd1, 64'h0, 64'h0, 64'h0, 64'h99}, "post_reset_lane0");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      s_axis_tvalid      = ($urandom_range(0, 3) != 0);
      s_axis_tlast       = ($urandom_range(0, 4) == 0);
      s_axis_tdata       = {$urandom, $urandom};
      m_axis_tready      = ($urandom_range(0, 3) != 0);
      m_axis_talmostfull = ($urandom_range(0, 7) == 0);
      cycle();
    end
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; m_axis_talmostfull = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
